// File: rtl/mem_resp_pkg.sv
// Shared types and default parameters for the system-side memory responder.
package mem_resp_pkg;

  // Responder sequencing: accept a request, wait out the fixed latency, then respond.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_MEM_AW      = 10;
  localparam int unsigned DEF_WAIT_STATES = 2;

  // Wait-state counter width; covers WAIT_STATES values 0..15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that times the wait states of one memory request.
// The zero flag is kept as its own register so it is valid in the same cycle
// as the count it describes.
module mem_wait_ctr
  import mem_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      zero    <= 1'b1;
    end else if (load) begin
      count_q <= load_val;
      zero    <= (load_val == '0);
    end else if (dec && !zero) begin
      count_q <= count_q - CNT_W'(1);
      zero    <= (count_q == CNT_W'(1));
    end
  end

endmodule

// File: rtl/sys_mem_responder.sv
// System-side responder for the cache S_* port: single-port word memory behind
// a fixed wait-state sequencer. One request at a time, no queuing.
module sys_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned MEM_AW      = DEF_MEM_AW,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  S_strobe,
  input  logic [ADDR_WIDTH-1:0] S_address,
  input  logic                  S_rw,
  input  logic [DATA_WIDTH-1:0] S_data_in,
  output logic [DATA_WIDTH-1:0] S_data_out,
  output logic                  S_ready
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  mem_state_t state_q;
  mem_state_t state_d;

  logic                  accept;
  logic                  access;
  logic                  ctr_load;
  logic                  ctr_dec;
  logic                  ctr_zero;

  logic [MEM_AW-1:0]     idx_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-offset and upper address bits do not select a word; addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_address[ADDR_WIDTH-1:MEM_AW+2], S_address[1:0]};

  // Times the WAIT phase; reaches zero on the cycle the access is performed.
  mem_wait_ctr u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; inputs are only looked at in IDLE.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    access   = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (S_strobe) begin
          accept   = 1'b1;
          ctr_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (ctr_zero) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture; held stable for the whole WAIT phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      idx_q   <= S_address[MEM_AW+1:2];
      rw_q    <= S_rw;
      wdata_q <= S_data_in;
    end
  end

  // Completion pulse: high exactly for the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_ready <= 1'b0;
    end else begin
      S_ready <= access;
    end
  end

  // Memory access: write commits or read lands on the last WAIT edge.
  // Array contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_data_out <= '0;
    end else if (access) begin
      if (rw_q) begin
        S_data_out <= mem[idx_q];
      end else begin
        mem[idx_q] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_sys_mem_responder.sv
// Self-checking bench for sys_mem_responder: a WAIT_STATES=2 instance for the
// main scenarios and a WAIT_STATES=0 instance for back-to-back streaming.
module tb_sys_mem_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // WAIT_STATES = 2 instance
  logic        strobe, rw, ready;
  logic [31:0] addr, wdata, rdata;
  // WAIT_STATES = 0 instance
  logic        strobe0, rw0, ready0;
  logic [31:0] addr0, wdata0, rdata0;

  sys_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .S_strobe(strobe), .S_address(addr), .S_rw(rw),
    .S_data_in(wdata), .S_data_out(rdata), .S_ready(ready)
  );

  sys_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .S_strobe(strobe0), .S_address(addr0), .S_rw(rw0),
    .S_data_in(wdata0), .S_data_out(rdata0), .S_ready(ready0)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: word array indexed modulo 1024 words, plus last read value.
  logic [31:0] model [1024];
  logic [31:0] last_rd;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  // Issue one request on the W=2 instance; returns cycles from sample to ready
  // (-1 on timeout) and the ready level one cycle after the pulse.
  task automatic req(input logic r, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic ready_after);
    @(negedge clk);
    strobe = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    strobe = 1'b0; rw = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
    lat = 1;
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ready) lat = -1;
    else if (r) last_rd = model[widx(a)];
    else model[widx(a)] = d;
    @(negedge clk);
    ready_after = ready;
  endtask

  task automatic test_reset();
    int lat; logic ra;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_data: got %h expected 00000000", rdata); end
    rst = 1'b0;
    last_rd = 32'h0;
    req(1'b0, 32'h80, 32'h1357_9BDF, lat, ra);
    req(1'b1, 32'h80, 32'h0, lat, ra);
    total++; if (rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL reset_pre_read: got %h expected 13579bdf", rdata); end
    // reset in the middle of WAIT
    @(negedge clk);
    strobe = 1'b1; rw = 1'b1; addr = 32'h80;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_mid_ready: got %b expected 0", ready); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_mid_data: got %h expected 00000000", rdata); end
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    req(1'b1, 32'h80, 32'h0, lat, ra);
    total++; if (lat !== 4) begin bad++; $display("FAIL reset_after_latency: got %0d expected 4", lat); end
    total++; if (rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL reset_after_data: got %h expected 13579bdf", rdata); end
  endtask

  task automatic test_write_read();
    int lat; logic ra;
    req(1'b0, 32'h10, 32'hDEAD_BEEF, lat, ra);
    total++; if (lat !== 4) begin bad++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL wr_pulse_width: got %b expected 0", ra); end
    req(1'b1, 32'h10, 32'h0, lat, ra);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    total++; if (ra !== 1'b0) begin bad++; $display("FAIL rd_pulse_width: got %b expected 0", ra); end
    total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_alias();
    int lat; logic ra;
    req(1'b0, 32'h0000_1004, 32'h1234_5678, lat, ra);
    req(1'b1, 32'h0000_0004, 32'h0, lat, ra);
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL alias_low: got %h expected 12345678", rdata); end
    req(1'b1, 32'hFFFF_F007, 32'h0, lat, ra);
    total++; if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL alias_high: got %h expected 12345678", rdata); end
  endtask

  task automatic test_busy_ignore();
    int pulses; int lat; logic ra;
    pulses = 0;
    @(negedge clk);
    strobe = 1'b1; rw = 1'b0; addr = 32'h20; wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    wdata = 32'h5555_5555;
    if (ready) pulses++;
    @(negedge clk);
    strobe = 1'b0;
    if (ready) pulses++;
    repeat (10) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    model[widx(32'h20)] = 32'hAAAA_AAAA;
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
    req(1'b1, 32'h20, 32'h0, lat, ra);
    total++; if (rdata !== 32'hAAAA_AAAA) begin bad++; $display("FAIL busy_data: got %h expected aaaaaaaa", rdata); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic ra;
    req(1'b0, 32'h40, 32'h0, lat, ra);
    @(negedge clk);
    strobe = 1'b1; rw = 1'b0; addr = 32'h40; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    req(1'b1, 32'h40, 32'h0, lat, ra);
    total++; if (lat !== 4) begin bad++; $display("FAIL rstwr_latency: got %0d expected 4", lat); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstwr_data: got %h expected 00000000", rdata); end
  endtask

  task automatic test_random();
    int lat; logic ra; logic do_rd; int wi;
    logic [31:0] a, d, prev;
    int written[$];
    for (int n = 0; n < 60; n++) begin
      do_rd = (written.size() != 0) && ($urandom_range(0, 2) != 0);
      if (do_rd) wi = written[$urandom_range(0, written.size() - 1)];
      else wi = int'(($urandom_range(0, 15) * 67) % 1024);
      a = ($urandom & 32'hFFFF_F003) | (32'(wi) << 2);
      d = $urandom;
      prev = last_rd;
      req(do_rd, a, d, lat, ra);
      if (!do_rd) written.push_back(wi);
      total++; if (lat !== 4) begin bad++; $display("FAIL rand_latency[%0d]: got %0d expected 4", n, lat); end
      if (do_rd) begin
        total++; if (rdata !== model[wi]) begin bad++; $display("FAIL rand_read[%0d]: got %h expected %h", n, rdata, model[wi]); end
      end else begin
        total++; if (rdata !== prev) begin bad++; $display("FAIL rand_write_hold[%0d]: got %h expected %h", n, rdata, prev); end
      end
    end
  endtask

  // Zero wait states, strobe held high: one response every 3 cycles.
  task automatic test_back_to_back();
    logic        op_rd [6];
    logic [31:0] op_a  [6];
    logic [31:0] op_d  [6];
    logic [31:0] m0    [1024];
    logic [31:0] last0, expv;
    int cnt; int extra;
    op_rd[0] = 1'b0; op_a[0] = 32'h100; op_d[0] = $urandom;
    op_rd[1] = 1'b0; op_a[1] = 32'h204; op_d[1] = $urandom;
    op_rd[2] = 1'b1; op_a[2] = 32'h100; op_d[2] = $urandom;
    op_rd[3] = 1'b0; op_a[3] = 32'h308; op_d[3] = $urandom;
    op_rd[4] = 1'b1; op_a[4] = 32'h204; op_d[4] = $urandom;
    op_rd[5] = 1'b1; op_a[5] = 32'h100; op_d[5] = $urandom;
    last0 = 32'h0;
    @(negedge clk);
    strobe0 = 1'b1; rw0 = op_rd[0]; addr0 = op_a[0]; wdata0 = op_d[0];
    for (int i = 0; i < 6; i++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!ready0 && cnt < 20);
      total++; if (cnt !== ((i == 0) ? 2 : 3)) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, cnt, (i == 0) ? 2 : 3); end
      if (op_rd[i]) begin
        expv = m0[widx(op_a[i])];
        last0 = expv;
      end else begin
        m0[widx(op_a[i])] = op_d[i];
        expv = last0;
      end
      total++; if (rdata0 !== expv) begin bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rdata0, expv); end
      if (i < 5) begin
        rw0 = op_rd[i+1]; addr0 = op_a[i+1]; wdata0 = op_d[i+1];
      end else begin
        strobe0 = 1'b0;
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL b2b_extra_ready: got %0d expected 0", extra); end
  endtask

  initial begin
    strobe = 1'b0;  rw = 1'b0;  addr = 32'h0;  wdata = 32'h0;
    strobe0 = 1'b0; rw0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    last_rd = 32'h0;
    test_reset();
    test_write_read();
    test_alias();
    test_busy_ignore();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
